// File: rtl/tpu_sequencer.sv
// tpu_sequencer: expands LOAD_A/LOAD_B/MATMUL/READ_C commands into per-cycle matrix-unit opcodes
module tpu_sequencer #(
  parameter int DIM = 8,
  parameter int MM_CYCLES = 3*DIM-2,
  parameter int CNTW = $clog2(MM_CYCLES+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic [2:0] tpu_opcode,
  output logic [3:0] tpu_idx,
  output logic       tpu_hl,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MATMUL, READ_C} state_t;
  localparam logic [CNTW-1:0] last_row = CNTW'(DIM-1);
  localparam logic [CNTW-1:0] last_mm = CNTW'(MM_CYCLES-1);
  localparam logic [CNTW-1:0] last_beat = CNTW'(2*DIM-1);
  state_t state;
  logic [CNTW-1:0] cnt;
  logic load, adv, fin;
  always_comb begin
    load = state == LOAD_A || state == LOAD_B;
    cmd_ready = state == IDLE;
    busy = !cmd_ready;
    din_ready = load;
    dout_valid = state == READ_C;
    dout_last = dout_valid && cnt == last_beat;
    tpu_opcode = state == LOAD_A ? (din_valid ? 3'd0 : 3'd7) :
                 state == LOAD_B ? (din_valid ? 3'd1 : 3'd7) :
                 state == MATMUL ? 3'd3 :
                 dout_valid ? 3'd4 : 3'd7;
    tpu_idx = (state == LOAD_A && din_valid) ? 4'(cnt) : dout_valid ? 4'(cnt >> 1) : 4'd0;
    tpu_hl = dout_valid & cnt[0];
    // a beat advances on its own handshake; matmul steps are unconditional
    adv = load ? din_valid : dout_valid ? dout_ready : state == MATMUL;
    fin = adv && cnt == (load ? last_row : dout_valid ? last_beat : last_mm);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE) begin
        if (cmd_valid) begin
          state <= state_t'(3'(cmd_op) + 3'd1);
          cnt <= '0;
        end
      end else if (fin) begin
        state <= IDLE;
        cnt <= '0;
      end else if (adv) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: randomized command/handshake stimulus against a beat-counting reference model
module tb_tpu_sequencer;
  localparam int DIM = 8;
  localparam int MM = 3*DIM-2;
  logic clk = 0, rst_n = 0, cmd_valid = 0, din_valid = 0, dout_ready = 0;
  logic [1:0] cmd_op = 0;
  logic cmd_ready, din_ready, dout_valid, dout_last, tpu_hl, busy, done;
  logic [2:0] tpu_opcode;
  logic [3:0] tpu_idx;
  int passed = 0, total = 0;
  bit dv_q[$];
  bit rdy_q[$];
  tpu_sequencer #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .din_valid(din_valid), .din_ready(din_ready), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .tpu_opcode(tpu_opcode), .tpu_idx(tpu_idx), .tpu_hl(tpu_hl),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic noise();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op = 2'($urandom_range(0, 3));
    din_valid = 1'($urandom_range(0, 1));
    dout_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic idle_checks(int exp_done);
    check("idle_done", int'(done), exp_done);
    check("idle_cmd_ready", int'(cmd_ready), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_opcode", int'(tpu_opcode), 7);
    check("idle_idx", int'(tpu_idx), 0);
    check("idle_hl", int'(tpu_hl), 0);
    check("idle_din_ready", int'(din_ready), 0);
    check("idle_dout_valid", int'(dout_valid), 0);
    check("idle_dout_last", int'(dout_last), 0);
  endtask
  task automatic busy_checks(string tag);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 0);
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_done"}, int'(done), 0);
  endtask
  task automatic idle_cycle(int exp_done);
    cmd_valid = 0;
    din_valid = 1'($urandom_range(0, 1));
    dout_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    idle_checks(exp_done);
    @(posedge clk); #1;
  endtask
  task automatic issue(int op, int exp_done);
    cmd_valid = 1;
    cmd_op = 2'(op);
    din_valid = 1'($urandom_range(0, 1));
    dout_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    idle_checks(exp_done);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  // expected: rows 0..DIM-1 in order, one per accepted din_valid
  task automatic do_load(int op);
    int row = 0;
    int cyc = 0;
    while (row < DIM && cyc < 200) begin
      noise();
      din_valid = dv_q.size() > 0 ? dv_q.pop_front() : 1'($urandom_range(0, 1));
      @(negedge clk);
      busy_checks("load");
      check("load_din_ready", int'(din_ready), 1);
      check("load_dout_valid", int'(dout_valid), 0);
      check("load_opcode", int'(tpu_opcode), din_valid ? op : 7);
      if (din_valid) begin
        check("load_idx", int'(tpu_idx), op == 0 ? row : 0);
        row++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("load_timeout", row, DIM);
  endtask
  task automatic do_matmul(int abort_at);
    for (int step = 0; step < MM; step++) begin
      noise();
      if (step == abort_at) rst_n = 0;
      @(negedge clk);
      busy_checks("mm");
      check("mm_opcode", int'(tpu_opcode), 3);
      check("mm_idx", int'(tpu_idx), 0);
      check("mm_din_ready", int'(din_ready), 0);
      @(posedge clk); #1;
      if (step == abort_at) begin
        rst_n = 1;
        cmd_valid = 0;
        @(negedge clk);
        idle_checks(0);
        @(posedge clk); #1;
        return;
      end
    end
  endtask
  // expected: beat k carries row k/2, half k%2; only accepted beats advance k
  task automatic do_read();
    int k = 0;
    int cyc = 0;
    while (k < 2*DIM && cyc < 300) begin
      noise();
      dout_ready = rdy_q.size() > 0 ? rdy_q.pop_front() : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      busy_checks("rd");
      check("rd_opcode", int'(tpu_opcode), 4);
      check("rd_idx", int'(tpu_idx), k / 2);
      check("rd_hl", int'(tpu_hl), k % 2);
      check("rd_dout_valid", int'(dout_valid), 1);
      check("rd_dout_last", int'(dout_last), k == 2*DIM-1 ? 1 : 0);
      check("rd_din_ready", int'(din_ready), 0);
      if (dout_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_timeout", k, 2*DIM);
  endtask
  task automatic run_body(int op);
    if (op == 0 || op == 1) do_load(op);
    else if (op == 2) do_matmul(-1);
    else do_read();
  endtask
  initial begin
    int pend;
    int op;
    repeat (2) begin
      noise();
      rst_n = 0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    idle_checks(0);
    @(posedge clk); #1;
    rst_n = 1;
    idle_cycle(0);
    dv_q = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    issue(0, 0);
    do_load(0);
    idle_cycle(1);
    idle_cycle(0);
    issue(2, 0);
    do_matmul(-1);
    idle_cycle(1);
    for (int k = 0; k < 2*DIM; k++) begin
      if (k == 3 || k == 10) begin
        rdy_q.push_back(0);
        rdy_q.push_back(0);
      end
      rdy_q.push_back(1);
    end
    issue(3, 0);
    do_read();
    idle_cycle(1);
    issue(0, 0);
    do_load(0);
    dv_q.push_back(1);
    issue(1, 1);
    do_load(1);
    idle_cycle(1);
    idle_cycle(0);
    issue(2, 0);
    do_matmul(10);
    idle_cycle(0);
    issue(2, 0);
    do_matmul(-1);
    idle_cycle(1);
    pend = 0;
    repeat (30) begin
      op = $urandom_range(0, 3);
      issue(op, pend);
      run_body(op);
      pend = 1;
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle(1);
        pend = 0;
      end
    end
    idle_cycle(pend);
    idle_cycle(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
